gsim_matvec: RTL and testbench

Forward banded matrix-vector engine, the counterpart of the Gauss-Seidel solver block. It takes the 16-element solution vector x that the solver emits (Q16.16, serial) and recomputes b = A·x with the same 16×16 banded system matrix. It then streams out 16 rounded, saturated 16-bit b values in the solver's input format. The bench and the top-level use it to close the loop: solver b_in → x_out → gsim_matvec → reconstructed b, which is compared against the original b.

---
 rtl/gsim_matvec.sv | 135 +++++++++++++
 tb/tb_gsim_matvec.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_matvec.sv
// Banded 16x16 matrix-vector engine: loads a serial Q16.16 vector x, then streams
// out b = A*x one row per cycle, rounded half-up and saturated to signed 16 bits.
module gsim_matvec (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [31:0] x_in,
    output logic        busy,
    output logic        out_valid,
    output logic [15:0] b_out,
    output logic        sat
);

    // Handshake: x_in is taken on any rising edge with in_en=1 while busy=0; there is no
    // back-pressure on the output, b_out/sat are meaningful only in cycles with out_valid=1.

    typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

    // All control state lives in this one struct so checkers can bind to a single signal.
    typedef struct packed {
        state_t     state;
        logic [3:0] idx;
        logic [3:0] row;
    } ctl_t;

    ctl_t ctl, ctl_nxt;
    logic rf_we;
    logic calc_en;

    logic [31:0]        rf [16];
    logic signed [37:0] acc;
    logic               acc_vld;

    logic signed [31:0] xw [7];
    logic signed [32:0] s1, s2, s3;
    logic signed [37:0] acc_nxt;
    logic signed [37:0] rnd;
    logic [15:0]        b_nxt;
    logic               sat_nxt;
    int                 col;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl <= '{state: LOAD, idx: 4'd0, row: 4'd0};
        end else begin
            ctl <= ctl_nxt;
        end
    end

    always_comb begin
        ctl_nxt = ctl;
        rf_we   = 1'b0;
        calc_en = 1'b0;
        case (ctl.state)
            LOAD: begin
                if (in_en) begin
                    rf_we       = 1'b1;
                    ctl_nxt.idx = ctl.idx + 4'd1;
                    if (ctl.idx == 4'd15) ctl_nxt.state = CALC;
                end
            end
            CALC: begin
                calc_en     = 1'b1;
                ctl_nxt.row = ctl.row + 4'd1;
                if (ctl.row == 4'd15) ctl_nxt.state = DRAIN;
            end
            DRAIN: begin
                // Row 15 is in the output register once acc_vld has dropped.
                if (!acc_vld) ctl_nxt = '{state: LOAD, idx: 4'd0, row: 4'd0};
            end
            default: ctl_nxt = '{state: LOAD, idx: 4'd0, row: 4'd0};
        endcase
    end

    assign busy = (ctl.state != LOAD);

    always_ff @(posedge clk) begin
        if (rf_we) rf[ctl.idx] <= x_in;
    end

    // Seven-tap window centred on the current row; taps outside 0..15 read as zero.
    always_comb begin
        col = 0;
        for (int d = 0; d < 7; d++) begin
            col   = int'(ctl.row) + d - 3;
            xw[d] = '0;
            if (col >= 0 && col <= 15) xw[d] = $signed(rf[col[3:0]]);
        end
    end

    always_comb begin
        s1 = $signed({xw[2][31], xw[2]}) + $signed({xw[4][31], xw[4]});
        s2 = $signed({xw[1][31], xw[1]}) + $signed({xw[5][31], xw[5]});
        s3 = $signed({xw[0][31], xw[0]}) + $signed({xw[6][31], xw[6]});
        acc_nxt = 38'sd20 * $signed({{6{xw[3][31]}}, xw[3]})
                - 38'sd13 * $signed({{5{s1[32]}}, s1})
                + 38'sd6  * $signed({{5{s2[32]}}, s2})
                - $signed({{5{s3[32]}}, s3});
    end

    always_comb begin
        rnd     = (acc + 38'sd32768) >>> 16;
        b_nxt   = rnd[15:0];
        sat_nxt = 1'b0;
        if (rnd > 38'sd32767) begin
            b_nxt   = 16'h7fff;
            sat_nxt = 1'b1;
        end else if (rnd < -38'sd32768) begin
            b_nxt   = 16'h8000;
            sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            acc_vld   <= 1'b0;
            out_valid <= 1'b0;
            b_out     <= '0;
            sat       <= 1'b0;
        end else begin
            acc_vld <= calc_en;
            if (calc_en) acc <= acc_nxt;
            out_valid <= acc_vld;
            if (acc_vld) begin
                b_out <= b_nxt;
                sat   <= sat_nxt;
            end else begin
                b_out <= '0;
                sat   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gsim_matvec.sv
// Self-checking bench for gsim_matvec: directed vectors, saturation, overrun/gaps
// and mid-vector reset, with a queue-based scoreboard against a behavioural model.
module tb_gsim_matvec;

    typedef logic [31:0] vec_t [16];

    logic        clk;
    logic        reset;
    logic        in_en;
    logic [31:0] x_in;
    logic        busy;
    logic        out_valid;
    logic [15:0] b_out;
    logic        sat;

    gsim_matvec dut (
        .clk(clk), .reset(reset), .in_en(in_en), .x_in(x_in),
        .busy(busy), .out_valid(out_valid), .b_out(b_out), .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int          got_cyc[$];
    int          fall_cyc = -1;
    logic        busy_d = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    // Output monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got_q.push_back({sat, b_out});
            got_cyc.push_back(cyc);
        end
        if (busy_d === 1'b1 && busy === 1'b0) fall_cyc = cyc;
        busy_d = busy;
    end

    function automatic logic [16:0] model_row(input vec_t v, input int i);
        longint acc;
        longint r;
        int     c;
        acc = 0;
        for (int j = 0; j < 16; j++) begin
            case (i - j)
                0:       c = 20;
                1, -1:   c = -13;
                2, -2:   c = 6;
                3, -3:   c = -1;
                default: c = 0;
            endcase
            acc += longint'(c) * longint'($signed(v[j]));
        end
        r = (acc + 64'sd32768) >>> 16;
        if (r > 32767)  return {1'b1, 16'h7fff};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    function automatic logic [31:0] rnd_x();
        logic [31:0] v;
        case ($urandom_range(0, 2))
            0:       v = $urandom;
            1:       v = 32'($signed(20'($urandom)));
            default: v = 32'($urandom_range(0, 3) << 16);
        endcase
        return v;
    endfunction

    task automatic push_model(input vec_t v);
        for (int i = 0; i < 16; i++) exp_q.push_back(model_row(v, i));
    endtask

    task automatic push_lit(input int b, input bit s);
        exp_q.push_back({s, 16'(b)});
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        fall_cyc = -1;
    endtask

    // Called at a negedge; returns at the negedge right after the x[15] capture edge.
    task automatic load_vec(input vec_t v, input int gap_pct, output int t_cap);
        for (int k = 0; k < 16; k++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_en = 1'b0;
                x_in  = $urandom;
                @(negedge clk);
            end
            in_en = 1'b1;
            x_in  = v[k];
            @(negedge clk);
        end
        in_en = 1'b0;
        t_cap = cyc;
    endtask

    task automatic wait_outputs(input int n);
        int budget;
        budget = 120;
        while (got_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        in_en = 1'b0;
        x_in  = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({busy, out_valid, sat} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, out_valid, sat});
        else n_pass++;
        n_total++;
        if (b_out !== 16'h0000) $display("FAIL reset_b_out: got %h expected 0000", b_out);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ones();
        vec_t v;
        int t;
        logic [16:0] e, g;
        clear_sb();
        for (int k = 0; k < 16; k++) v[k] = 32'h0001_0000;
        push_lit(12, 0); push_lit(-1, 0); push_lit(5, 0);
        for (int i = 3; i <= 12; i++) push_lit(4, 0);
        push_lit(5, 0); push_lit(-1, 0); push_lit(12, 0);
        load_vec(v, 0, t);
        n_total++;
        if (busy !== 1'b1) $display("FAIL ones_busy_rise: got %b expected 1", busy);
        else n_pass++;
        wait_outputs(16);
        n_total++;
        if (got_q.size() != 16) $display("FAIL ones_count: got %0d expected 16", got_q.size());
        else n_pass++;
        n_total++;
        if (got_cyc.size() == 0 || got_cyc[0] - t != 2)
            $display("FAIL ones_latency: got %0d expected 2", got_cyc.size() == 0 ? -1 : got_cyc[0] - t);
        else n_pass++;
        n_total++;
        if (got_cyc.size() != 16 || got_cyc[15] - got_cyc[0] != 15)
            $display("FAIL ones_no_gaps: got span %0d expected 15", got_cyc.size() < 2 ? -1 : got_cyc[got_cyc.size()-1] - got_cyc[0]);
        else n_pass++;
        n_total++;
        if (fall_cyc - t != 18) $display("FAIL ones_busy_fall: got %0d expected 18", fall_cyc - t);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (got_q.size() == 0) $display("FAIL ones_row: got none expected %0d", $signed(e[15:0]));
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL ones_row: got sat=%b b=%0d expected sat=%b b=%0d", g[16], $signed(g[15:0]), e[16], $signed(e[15:0]));
                else n_pass++;
            end
        end
    endtask

    // Covers single impulse, half-up rounding and saturation with literal expectations.
    task automatic test_directed(input int which);
        vec_t v;
        int t;
        logic [16:0] e, g;
        clear_sb();
        for (int k = 0; k < 16; k++) v[k] = '0;
        case (which)
            0: begin
                v[5] = 32'h0001_0000;
                for (int i = 0; i < 2; i++) push_lit(0, 0);
                push_lit(-1, 0); push_lit(6, 0); push_lit(-13, 0); push_lit(20, 0);
                push_lit(-13, 0); push_lit(6, 0); push_lit(-1, 0);
                for (int i = 9; i < 16; i++) push_lit(0, 0);
            end
            1: begin
                v[0] = 32'h0000_8000;
                push_lit(10, 0); push_lit(-6, 0); push_lit(3, 0);
                for (int i = 3; i < 16; i++) push_lit(0, 0);
            end
            default: begin
                for (int k = 0; k < 16; k++) v[k] = 32'h7fff_ffff;
                push_lit(32767, 1); push_lit(-32768, 0);
                for (int i = 2; i <= 13; i++) push_lit(32767, 1);
                push_lit(-32768, 0); push_lit(32767, 1);
            end
        endcase
        load_vec(v, 0, t);
        wait_outputs(16);
        n_total++;
        if (got_q.size() != 16) $display("FAIL directed%0d_count: got %0d expected 16", which, got_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (got_q.size() == 0) $display("FAIL directed%0d_row: got none expected %0d", which, $signed(e[15:0]));
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL directed%0d_row: got sat=%b b=%0d expected sat=%b b=%0d", which, g[16], $signed(g[15:0]), e[16], $signed(e[15:0]));
                else n_pass++;
            end
        end
    endtask

    task automatic test_overrun_gaps();
        logic [31:0] s [50];
        vec_t v1, v2;
        int t;
        logic [16:0] e, g;
        clear_sb();
        for (int k = 0; k < 50; k++) s[k] = rnd_x();
        for (int k = 0; k < 16; k++) begin
            v1[k] = s[k];
            v2[k] = s[34 + k];
        end
        push_model(v1);
        push_model(v2);
        // Continuous stream: s[16..33] land while busy (s[33] on the busy-fall edge).
        for (int k = 0; k < 50; k++) begin
            if (k == 40) begin
                in_en = 1'b0;
                repeat (5) @(negedge clk);
            end
            in_en = 1'b1;
            x_in  = s[k];
            @(negedge clk);
        end
        in_en = 1'b0;
        wait_outputs(32);
        n_total++;
        if (got_q.size() != 32) $display("FAIL overrun_count: got %0d expected 32", got_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (got_q.size() == 0) $display("FAIL overrun_row: got none expected %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL overrun_row: got %h expected %h", g, e);
                else n_pass++;
            end
        end
        clear_sb();
        push_model(v1);
        load_vec(v1, 40, t);
        wait_outputs(16);
        n_total++;
        if (got_cyc.size() == 0 || got_cyc[0] - t != 2)
            $display("FAIL gaps_latency: got %0d expected 2", got_cyc.size() == 0 ? -1 : got_cyc[0] - t);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (got_q.size() == 0) $display("FAIL gaps_row: got none expected %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL gaps_row: got %h expected %h", g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t v1, v2;
        int t;
        logic [16:0] e, g;
        clear_sb();
        for (int k = 0; k < 16; k++) begin
            v1[k] = rnd_x();
            v2[k] = rnd_x();
        end
        for (int k = 0; k < 8; k++) begin
            in_en = 1'b1;
            x_in  = v1[k];
            @(negedge clk);
        end
        in_en = 1'b0;
        reset = 1'b0;
        #1;
        n_total++;
        if ({busy, out_valid, sat, b_out} !== 19'd0) $display("FAIL midload_reset: got %h expected 0", {busy, out_valid, sat, b_out});
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        repeat (24) @(negedge clk);
        n_total++;
        if (got_q.size() != 0) $display("FAIL midload_no_valid: got %0d expected 0", got_q.size());
        else n_pass++;
        push_model(v2);
        load_vec(v2, 0, t);
        wait_outputs(16);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (got_q.size() == 0) $display("FAIL midload_row: got none expected %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL midload_row: got %h expected %h", g, e);
                else n_pass++;
            end
        end
        // Abort during CALC after rows 0..3 have been presented.
        clear_sb();
        load_vec(v1, 0, t);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if ({busy, out_valid} !== 2'b00) $display("FAIL midcalc_reset: got %b expected 00", {busy, out_valid});
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        n_total++;
        if (got_q.size() != 4) $display("FAIL midcalc_count: got %0d expected 4", got_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
            e = model_row(v1, i);
            g = got_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL midcalc_row: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_directed(0);
        test_directed(1);
        test_directed(2);
        test_overrun_gaps();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
